// File: rtl/lif_cfg_serializer.sv
// Frames a parallel parameter word onto the LIF neuron's serial config port (MSB first), then waits for params_ready.
// Optional build macro LIF_CFG_PARITY_EN appends an even-parity bit after the LSB.
module lif_cfg_serializer #(
  parameter int unsigned PARAM_BITS = 16,
  parameter int unsigned BIT_DIV    = 1,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [PARAM_BITS-1:0] param_word,
  input  logic                  params_ready,
  output logic                  load_mode,
  output logic                  serial_data,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err
);

`ifdef LIF_CFG_PARITY_EN
  localparam int unsigned FRAME_BITS = PARAM_BITS + 1;
`else
  localparam int unsigned FRAME_BITS = PARAM_BITS;
`endif
  localparam int unsigned BIT_CNT_W  = $clog2(FRAME_BITS + 1);
  localparam int unsigned DIV_CNT_W  = $clog2(BIT_DIV + 1);
  localparam int unsigned WAIT_CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_WAIT,
    ST_FIN
  } state_e;

  state_e                  state_q, state_d;
  logic [FRAME_BITS-1:0]   sr_q, sr_d;
  logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DIV_CNT_W-1:0]    div_cnt_q, div_cnt_d;
  logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                    terr_q, terr_d;
  logic                    load_mode_q, load_mode_d;
  logic                    serial_q, serial_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [FRAME_BITS-1:0]   frame_word;

`ifdef LIF_CFG_PARITY_EN
  assign frame_word = {param_word, ^param_word};
`else
  assign frame_word = param_word;
`endif

  // Outputs are registered from the current state, so they trail the state by one clock.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    bit_cnt_d   = bit_cnt_q;
    div_cnt_d   = div_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    terr_d      = terr_q;
    load_mode_d = 1'b0;
    serial_d    = 1'b0;
    busy_d      = (state_q != ST_IDLE);
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sr_d    = frame_word;
          terr_d  = 1'b0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        load_mode_d = 1'b1;
        bit_cnt_d   = '0;
        div_cnt_d   = '0;
        state_d     = ST_SHIFT;
      end
      ST_SHIFT: begin
        load_mode_d = 1'b1;
        serial_d    = sr_q[FRAME_BITS-1];
        if (div_cnt_q == DIV_CNT_W'(BIT_DIV - 1)) begin
          div_cnt_d = '0;
          sr_d      = sr_q << 1;
          if (bit_cnt_q == BIT_CNT_W'(FRAME_BITS - 1)) begin
            wait_cnt_d = '0;
            state_d    = ST_WAIT;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (params_ready) begin
          state_d = ST_FIN;
        end else if (wait_cnt_q == WAIT_CNT_W'(TIMEOUT - 1)) begin
          terr_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
        end
      end
      ST_FIN: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides start and params_ready; the error flag is left alone.
    if (abort) begin
      state_d     = ST_IDLE;
      sr_d        = sr_q;
      terr_d      = terr_q;
      load_mode_d = 1'b0;
      serial_d    = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      div_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      terr_q      <= 1'b0;
      load_mode_q <= 1'b0;
      serial_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      div_cnt_q   <= div_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      terr_q      <= terr_d;
      load_mode_q <= load_mode_d;
      serial_q    <= serial_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign load_mode   = load_mode_q;
  assign serial_data = serial_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = terr_q;

endmodule

// File: doc/lif_cfg_serializer.md
Name: lif_cfg_serializer

Overview:
- Drives the serial configuration port of the LIF neuron: `load_mode`, `serial_data`, and the `params_ready` return.
- Accepts a parallel parameter word from the host/controller logic.
- Shifts the word out MSB-first as a framed serial stream, then waits for the neuron to report `params_ready`.
- Sits on the controller side of the neuron's config port, for on-chip self-configuration and test harnesses.

Parameters:
- PARAM_BITS, 16, width of the parameter word shifted per frame (2..32).
- BIT_DIV, 1, clocks each serial bit is held (1..255).
- TIMEOUT, 64, max clocks to wait for params_ready after the last bit (1..65535).

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a frame; sampled only in IDLE
- abort  input  1  synchronous cancel of any frame in progress
- param_word  input  PARAM_BITS  parameter data, latched on accepted start
- params_ready  input  1  status returned by the neuron
- load_mode  output  1  to neuron config-mode control
- serial_data  output  1  to neuron serial data input
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse on successful completion
- timeout_err  output  1  sticky; set on timeout, cleared on next accepted start or reset

Behaviour:
- Reset (async assert): state=IDLE. load_mode=0, serial_data=0, busy=0, done=0, timeout_err=0, shift register and counters cleared. Outputs go low immediately, mid-frame included.
- All outputs are registered.
- FSM states: IDLE, SETUP, SHIFT, WAIT, FIN.
- IDLE:
  - start=1 at an edge → latch param_word, clear timeout_err, go to SETUP.
  - start outside IDLE is ignored (no queueing).
- SETUP: one clock; load_mode=1, serial_data=0. Next state SHIFT.
- SHIFT:
  - load_mode=1; serial_data = current MSB of the shift register.
  - Each bit is held exactly BIT_DIV clocks, then the register shifts left.
  - After PARAM_BITS bits (plus parity if enabled) go to WAIT.
  - SHIFT duration = PARAM_BITS*BIT_DIV clocks.
- WAIT:
  - load_mode=0, serial_data=0; wait counter starts at 0.
  - params_ready=1 on any WAIT clock → FIN.
  - Counter reaches TIMEOUT with no params_ready → set timeout_err, go to IDLE, no done pulse.
  - params_ready already high on the first WAIT clock counts as success.
- FIN: done=1 for exactly one clock, then IDLE.
- abort=1 in any state:
  - Next state IDLE; load_mode=0, serial_data=0 next clock; no done; timeout_err unchanged.
  - abort has priority over start and over params_ready in the same cycle.
- Counter widths are sized from the parameters; no wrap inside a frame. The bit counter ends exactly at frame length.
- Latency with BIT_DIV=1, start accepted at edge 0:
  - load_mode high on edges 1..PARAM_BITS+1.
  - First WAIT clock at edge PARAM_BITS+2.
  - Earliest done at edge PARAM_BITS+3.

Optional Feature:
- Macro: LIF_CFG_PARITY_EN.
- Defined: one extra bit follows the LSB — even parity (XOR of all PARAM_BITS data bits), held BIT_DIV clocks with load_mode=1. SHIFT lasts (PARAM_BITS+1)*BIT_DIV clocks and all later timing shifts by BIT_DIV.
- Undefined: frame is data bits only, and no parity logic is synthesized.

Test Plan:
- Basic frame: PARAM_BITS=16, BIT_DIV=1, param_word=16'hA5C3, params_ready tied high.
  - serial_data on edges 2..17 = 1010_0101_1100_0011.
  - load_mode high on edges 1..17; done pulse at edge 19; busy low at edge 20.
- Timeout: BIT_DIV=2, TIMEOUT=8, params_ready held 0 → timeout_err=1 after 8 WAIT clocks, done never asserted. The next start clears timeout_err on the following edge.
- Abort mid-shift: abort at the 5th SHIFT clock → load_mode=0 and busy=0 the next clock, no done, serial_data=0.
- Reset mid-frame: assert reset asynchronously between edges during SHIFT → load_mode/serial_data/busy low before the next edge. After release, start with 16'h0001 gives a clean full frame.
- Ignored start: start pulsed during WAIT with a different param_word → no new frame, latched data unchanged, single done.
- LIF_CFG_PARITY_EN defined, param_word=16'h0007 → 17th bit=1 (three ones), load_mode high for 18 clocks; with 16'h0003 the parity bit=0.
